// File: rtl/acq_cmd_pkg.sv
// Shared constants, command encodings and state types for the acquisition
// command parser and sequencer.
package acq_cmd_pkg;

    localparam logic [7:0] HDR0_DEF  = 8'hEB;
    localparam logic [7:0] HDR1_DEF  = 8'h90;

    localparam logic [7:0] CMD_DAQ   = 8'h0F;
    localparam logic [7:0] CMD_REC   = 8'hF0;
    localparam logic [7:0] CMD_BOTH  = 8'hFF;
    localparam logic [7:0] CMD_STOP  = 8'h00;

    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_NACK = 8'h5A;

    typedef enum logic [2:0] { P_H0, P_H1, P_CMD, P_ARG, P_CHK } parse_state_e;
    typedef enum logic       { IDLE, RUN } seq_state_e;

    // An all-zero mode is the stop command.
    typedef struct packed {
        logic rec;
        logic daq;
    } acq_mode_t;

    localparam acq_mode_t MODE_STOP = '0;

    function automatic logic is_known_cmd(input logic [7:0] cmd);
        return (cmd == CMD_DAQ) || (cmd == CMD_REC) || (cmd == CMD_BOTH) || (cmd == CMD_STOP);
    endfunction

    function automatic acq_mode_t decode_mode(input logic [7:0] cmd);
        acq_mode_t m;
        m.daq = (cmd == CMD_DAQ) || (cmd == CMD_BOTH);
        m.rec = (cmd == CMD_REC) || (cmd == CMD_BOTH);
        return m;
    endfunction

endpackage

// File: rtl/acq_frame_parser.sv
// Byte-level frame parser: header sync, checksum/command check, inter-byte
// timeout and the single-entry ack/nack response register.
module acq_frame_parser
    import acq_cmd_pkg::*;
#(
    parameter int unsigned BYTE_TIMEOUT = 50000,
    parameter logic [7:0]  HDR0         = HDR0_DEF,
    parameter logic [7:0]  HDR1         = HDR1_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] rx_data,
    input  logic       resp_ready,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       frame_err,
    output logic       cmd_go,
    output acq_mode_t  cmd_mode,
    output logic [7:0] cmd_n
);

    localparam int unsigned TW = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [TW-1:0] IDLE_LIMIT = TW'(BYTE_TIMEOUT);

    parse_state_e  state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    arg_q, arg_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          cmd_go_q, cmd_go_d;
    acq_mode_t     mode_q, mode_d;
    logic [7:0]    n_q, n_d;
    logic          frame_err_q, frame_err_d;
    logic          resp_valid_q, resp_valid_d;
    logic [7:0]    resp_data_q, resp_data_d;

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        arg_d        = arg_q;
        idle_d       = idle_q;
        cmd_go_d     = 1'b0;
        mode_d       = mode_q;
        n_d          = n_q;
        frame_err_d  = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;

        if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end

        if (valid) begin
            idle_d = '0;
            case (state_q)
                P_H0: if (rx_data == HDR0) state_d = P_H1;
                P_H1: begin
                    if (rx_data == HDR1) begin
                        state_d = P_CMD;
                    end else if (rx_data != HDR0) begin
                        state_d = P_H0;
                    end
                end
                P_CMD: begin
                    cmd_d   = rx_data;
                    state_d = P_ARG;
                end
                P_ARG: begin
                    arg_d   = rx_data;
                    state_d = P_CHK;
                end
                P_CHK: begin
                    // A new verdict overwrites any unconsumed response.
                    state_d      = P_H0;
                    resp_valid_d = 1'b1;
                    if ((rx_data == (cmd_q ^ arg_q)) && is_known_cmd(cmd_q)) begin
                        cmd_go_d    = 1'b1;
                        mode_d      = decode_mode(cmd_q);
                        n_d         = arg_q;
                        resp_data_d = RESP_ACK;
                    end else begin
                        frame_err_d = 1'b1;
                        resp_data_d = RESP_NACK;
                    end
                end
                default: state_d = P_H0;
            endcase
        end else if (state_q != P_H0) begin
            idle_d = idle_q + TW'(1);
            if (idle_d == IDLE_LIMIT) begin
                state_d     = P_H0;
                idle_d      = '0;
                frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= P_H0;
            cmd_q        <= '0;
            arg_q        <= '0;
            idle_q       <= '0;
            cmd_go_q     <= 1'b0;
            mode_q       <= '0;
            n_q          <= '0;
            frame_err_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            arg_q        <= arg_d;
            idle_q       <= idle_d;
            cmd_go_q     <= cmd_go_d;
            mode_q       <= mode_d;
            n_q          <= n_d;
            frame_err_q  <= frame_err_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign frame_err  = frame_err_q;
    assign cmd_go     = cmd_go_q;
    assign cmd_mode   = mode_q;
    assign cmd_n      = n_q;

endmodule

// File: rtl/acq_cmd_sequencer.sv
// Acquisition sequencer: turns parsed commands into DAQ/RECORD enables and a
// periodic sample strobe, counted for N samples or continuous.
module acq_cmd_sequencer
    import acq_cmd_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV   = 1000,
    parameter int unsigned BYTE_TIMEOUT = 50000,
    parameter logic [7:0]  HDR0         = HDR0_DEF,
    parameter logic [7:0]  HDR1         = HDR1_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] rx_data,
    output logic       daq_en,
    output logic       record_en,
    output logic       sample_stb,
    output logic       busy,
    output logic       done,
    output logic       frame_err,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    input  logic       resp_ready
);

    localparam int unsigned DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

    logic       cmd_go;
    acq_mode_t  cmd_mode;
    logic [7:0] cmd_n;

    acq_frame_parser #(
        .BYTE_TIMEOUT (BYTE_TIMEOUT),
        .HDR0         (HDR0),
        .HDR1         (HDR1)
    ) u_parser (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .rx_data    (rx_data),
        .resp_ready (resp_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .frame_err  (frame_err),
        .cmd_go     (cmd_go),
        .cmd_mode   (cmd_mode),
        .cmd_n      (cmd_n)
    );

    seq_state_e    state_q, state_d;
    acq_mode_t     mode_q, mode_d;
    logic [7:0]    n_q, n_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic          daq_en_q, daq_en_d;
    logic          record_en_q, record_en_d;
    logic          sample_stb_q, sample_stb_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tick_c;

    assign tick_c = (state_q == RUN) && (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        done_d  = 1'b0;

        if (state_q == RUN) begin
            div_d = tick_c ? '0 : div_q + DW'(1);
            // Continuous runs (N == 0) leave the sample counter frozen.
            if (tick_c && (n_q != 8'd0)) begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_d == n_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
        end

        // A command in the same cycle as the final strobe takes priority.
        if (cmd_go) begin
            done_d = 1'b0;
            div_d  = '0;
            cnt_d  = '0;
            if (cmd_mode == MODE_STOP) begin
                state_d = IDLE;
            end else begin
                state_d = RUN;
                mode_d  = cmd_mode;
                n_d     = cmd_n;
            end
        end

        busy_d       = (state_d == RUN);
        daq_en_d     = busy_d && mode_d.daq;
        record_en_d  = busy_d && mode_d.rec;
        sample_stb_d = busy_d && (div_d == DIV_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= '0;
            n_q          <= '0;
            cnt_q        <= '0;
            div_q        <= '0;
            daq_en_q     <= 1'b0;
            record_en_q  <= 1'b0;
            sample_stb_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            n_q          <= n_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            daq_en_q     <= daq_en_d;
            record_en_q  <= record_en_d;
            sample_stb_q <= sample_stb_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign daq_en     = daq_en_q;
    assign record_en  = record_en_q;
    assign sample_stb = sample_stb_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_acq_cmd_sequencer.sv
// Scoreboard bench for acq_cmd_sequencer: stimulus queues expected events,
// a monitor checks every output each cycle against a timing-rule model.
module tb_acq_cmd_sequencer;

    localparam int DIV = 4;
    localparam int TO  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       resp_ready = 1'b1;
    logic       daq_en, record_en, sample_stb, busy, done, frame_err, resp_valid;
    logic [7:0] resp_data;

    acq_cmd_sequencer #(
        .SAMPLE_DIV   (DIV),
        .BYTE_TIMEOUT (TO),
        .HDR0         (8'hEB),
        .HDR1         (8'h90)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .rx_data    (rx_data),
        .daq_en     (daq_en),
        .record_en  (record_en),
        .sample_stb (sample_stb),
        .busy       (busy),
        .done       (done),
        .frame_err  (frame_err),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int t; logic [7:0] data; } resp_ev_t;
    typedef struct { int t; bit stop; bit daq; bit rec; int n; } cmd_ev_t;

    resp_ev_t resp_q[$];
    cmd_ev_t  cmd_q[$];
    int       ferr_q[$];

    int  n_checks = 0;
    int  n_errors = 0;
    bit  mon_en = 1'b0;
    int  rdy_mode = 0;

    // Reference state: the current run and the pending response slot.
    bit         m_run = 1'b0;
    int         m_t0 = 0;
    bit         m_daq = 1'b0;
    bit         m_rec = 1'b0;
    int         m_n = 0;
    bit         p_valid = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       e_busy, e_stb, e_done, e_ferr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (resp_q.size() > 0 && resp_q[0].t <= cyc) begin
                    p_valid = 1'b1;
                    p_data  = resp_q[0].data;
                    void'(resp_q.pop_front());
                end
                e_ferr = 1'b0;
                if (ferr_q.size() > 0 && ferr_q[0] == cyc) begin
                    e_ferr = 1'b1;
                    void'(ferr_q.pop_front());
                end
                e_busy = m_run && (cyc > m_t0) && (m_n == 0 || cyc <= m_t0 + m_n * DIV);
                e_stb  = e_busy && ((cyc - m_t0) % DIV == 0);
                e_done = m_run && (m_n != 0) && (cyc == m_t0 + m_n * DIV + 1);

                chk("resp_valid", 32'(resp_valid), 32'(p_valid));
                if (p_valid) chk("resp_data", 32'(resp_data), 32'(p_data));
                chk("frame_err", 32'(frame_err), 32'(e_ferr));
                chk("busy", 32'(busy), 32'(e_busy));
                chk("daq_en", 32'(daq_en), 32'(e_busy && m_daq));
                chk("record_en", 32'(record_en), 32'(e_busy && m_rec));
                chk("sample_stb", 32'(sample_stb), 32'(e_stb));
                chk("done", 32'(done), 32'(e_done));

                if (p_valid && resp_ready) p_valid = 1'b0;
                if (cmd_q.size() > 0 && cmd_q[0].t == cyc) begin
                    if (cmd_q[0].stop) begin
                        m_run = 1'b0;
                    end else begin
                        m_run = 1'b1;
                        m_t0  = cyc;
                        m_daq = cmd_q[0].daq;
                        m_rec = cmd_q[0].rec;
                        m_n   = cmd_q[0].n;
                    end
                    void'(cmd_q.pop_front());
                end
                if (rst) begin
                    m_run   = 1'b0;
                    p_valid = 1'b0;
                    resp_q.delete();
                    cmd_q.delete();
                    ferr_q.delete();
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       resp_ready = 1'b0;
                2:       resp_ready = 1'b1;
                default: resp_ready = ($urandom_range(3, 0) != 0);
            endcase
        end
    end

    task automatic tick_idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            valid = 1'b0;
        end
    endtask

    task automatic put(input logic [7:0] b, output int t);
        @(posedge clk);
        #1;
        valid   = 1'b1;
        rx_data = b;
        t       = cyc;
    endtask

    task automatic gap();
        tick_idle(int'($urandom_range(3, 0)));
    endtask

    // Expected outcome of a frame whose checksum byte was presented at cycle t.
    task automatic expect_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k, input int t);
        bit       known;
        bit       good;
        resp_ev_t r;
        cmd_ev_t  e;
        known = (c == 8'h0F) || (c == 8'hF0) || (c == 8'hFF) || (c == 8'h00);
        good  = known && (k == (c ^ a));
        r.t    = t + 1;
        r.data = good ? 8'hA5 : 8'h5A;
        resp_q.push_back(r);
        if (!good) begin
            ferr_q.push_back(t + 1);
        end else begin
            e.t    = t + 1;
            e.stop = (c == 8'h00);
            e.daq  = (c == 8'h0F) || (c == 8'hFF);
            e.rec  = (c == 8'hF0) || (c == 8'hFF);
            e.n    = int'(a);
            cmd_q.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
        int t;
        put(8'hEB, t); gap();
        put(8'h90, t); gap();
        put(c, t);     gap();
        put(a, t);     gap();
        put(k, t);
        expect_frame(c, a, k, t);
        tick_idle(1);
    endtask

    task automatic send_partial(input int nb);
        int t;
        put(8'hEB, t);
        if (nb > 1) begin gap(); put(8'h90, t); end
        if (nb > 2) begin gap(); put(8'($urandom), t); end
        if (nb > 3) begin gap(); put(8'($urandom), t); end
        ferr_q.push_back(t + TO + 1);
        tick_idle(TO + 1 + int'($urandom_range(4, 0)));
    endtask

    task automatic send_noise();
        int         t;
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'hEB) b = 8'h11;
        put(b, t);
        gap();
        put(8'hEB, t);
        b = 8'($urandom);
        if (b == 8'h90 || b == 8'hEB) b = 8'h55;
        put(b, t);
        tick_idle(1);
    endtask

    task automatic do_reset(input int k);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        valid = 1'b0;
        repeat (k - 1) @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [7:0] pick_start();
        case ($urandom_range(2, 0))
            0:       return 8'h0F;
            1:       return 8'hF0;
            default: return 8'hFF;
        endcase
    endfunction

    initial begin
        int         t;
        int         op;
        logic [7:0] c;
        logic [7:0] a;

        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick_idle(2);

        // Reset mid-frame, then a fresh counted DAQ run of 3 samples.
        put(8'hEB, t); put(8'h90, t); put(8'h0F, t);
        do_reset(3);
        tick_idle(2);
        send_frame(8'h0F, 8'h03, 8'h0C);
        tick_idle(20);

        // Continuous both, then stop.
        send_frame(8'hFF, 8'h00, 8'hFF);
        tick_idle(30);
        send_frame(8'h00, 8'h00, 8'h00);
        tick_idle(6);

        // Bad checksum and unknown command.
        send_frame(8'hF0, 8'h02, 8'h00);
        tick_idle(3);
        send_frame(8'h33, 8'h00, 8'h33);
        tick_idle(3);

        // Timeout after CMD, then resync through a repeated header byte.
        send_partial(3);
        put(8'hEB, t); put(8'hEB, t); put(8'h90, t);
        put(8'hF0, t); put(8'h01, t); put(8'hF1, t);
        expect_frame(8'hF0, 8'h01, 8'hF1, t);
        tick_idle(12);

        // Two acks with the consumer stalled, then release.
        rdy_mode = 1;
        tick_idle(2);
        send_frame(8'h0F, 8'h00, 8'h0F);
        send_frame(8'hF0, 8'h02, 8'hF2);
        tick_idle(6);
        rdy_mode = 2;
        tick_idle(12);
        rdy_mode = 0;

        for (int i = 0; i < 160; i++) begin
            op = int'($urandom_range(99, 0));
            if (op < 35) begin
                c = pick_start();
                a = 8'($urandom_range(5, 0));
                send_frame(c, a, c ^ a);
            end else if (op < 45) begin
                a = 8'($urandom);
                send_frame(8'h00, a, a);
            end else if (op < 55) begin
                c = pick_start();
                a = 8'($urandom_range(5, 0));
                send_frame(c, a, c ^ a ^ 8'($urandom_range(255, 1)));
            end else if (op < 63) begin
                c = 8'($urandom);
                if (c == 8'h0F || c == 8'hF0 || c == 8'hFF || c == 8'h00) c = 8'h3C;
                a = 8'($urandom);
                send_frame(c, a, c ^ a);
            end else if (op < 71) begin
                send_partial(int'($urandom_range(4, 1)));
            end else if (op < 85) begin
                send_noise();
            end else if (op < 89) begin
                do_reset(int'($urandom_range(3, 1)));
            end
            if ($urandom_range(4, 0) == 0) rdy_mode = int'($urandom_range(2, 0));
            if (rdy_mode == 1 && $urandom_range(1, 0) == 0) rdy_mode = 0;
            tick_idle(int'($urandom_range(25, 0)));
        end

        rdy_mode = 2;
        send_frame(8'h00, 8'h00, 8'h00);
        tick_idle(40);
        chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        chk("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
        chk("ferr_queue_drained", 32'(ferr_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
